reg_dump_tx: RTL and testbench

- Debug readout for the 8 x 32-bit register file: the reading end of its rf0..rf7 debug outputs.
- On a start pulse it snapshots all eight registers, then streams them out as framed bytes over a valid/ready interface.
- Sits between the CPU core and the board-level byte sink (UART TX or LED scanner).
- Lets a host dump architectural state without halting the core.

---
 rtl/reg_dump_tx_pkg.sv | 17 +
 rtl/reg_dump_mux.sv | 33 +++
 rtl/reg_dump_tx.sv | 124 ++++++++++++
 tb/tb_reg_dump_tx.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/reg_dump_tx_pkg.sv
// Shared types and constants for the register-file dump streamer.
package reg_dump_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA,
        CSUM
    } state_t;

    localparam int         NUM_REGS_DEF = 8;
    localparam logic [3:0] HDR_TAG_DEF  = 4'hA;
    localparam int         FRAME_BYTES  = 5 * NUM_REGS_DEF + 1;
    localparam int         REG_IDX_W    = 3;
    localparam int         BYTE_IDX_W   = 2;

endpackage

// File: rtl/reg_dump_mux.sv
// Selects the next stream byte: a formatted header or one byte of a snapshot word.
module reg_dump_mux
    import reg_dump_tx_pkg::*;
#(
    parameter int         NUM_REGS = NUM_REGS_DEF,
    parameter logic [3:0] HDR_TAG  = HDR_TAG_DEF
) (
    input  logic [NUM_REGS-1:0][31:0] snap,
    input  logic [REG_IDX_W-1:0]      reg_idx,
    input  logic [BYTE_IDX_W-1:0]     byte_idx,
    input  logic                      hdr_sel,
    output logic [7:0]                byte_out
);

    logic [31:0] word;

    always_comb begin
        word     = snap[reg_idx];
        byte_out = '0;
        if (hdr_sel) begin
            byte_out = {HDR_TAG, 1'b0, reg_idx};
        end else begin
            // Byte index 0 is the most significant byte of the word.
            case (byte_idx)
                2'd0:    byte_out = word[31:24];
                2'd1:    byte_out = word[23:16];
                2'd2:    byte_out = word[15:8];
                default: byte_out = word[7:0];
            endcase
        end
    end

endmodule

// File: rtl/reg_dump_tx.sv
// Snapshots the 8 x 32-bit register file on start and streams it as a framed,
// checksummed byte sequence over a valid/ready interface.
module reg_dump_tx
    import reg_dump_tx_pkg::*;
#(
    parameter int         NUM_REGS = NUM_REGS_DEF,
    parameter logic [3:0] HDR_TAG  = HDR_TAG_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] rf0,
    input  logic [31:0] rf1,
    input  logic [31:0] rf2,
    input  logic [31:0] rf3,
    input  logic [31:0] rf4,
    input  logic [31:0] rf5,
    input  logic [31:0] rf6,
    input  logic [31:0] rf7,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
);

    state_t                    state;
    logic [REG_IDX_W-1:0]      reg_idx, nxt_reg;
    logic [BYTE_IDX_W-1:0]     byte_idx, nxt_byte;
    logic                      nxt_hdr, nxt_csum;
    logic [7:0]                csum, mux_byte;
    logic [NUM_REGS-1:0][31:0] snap;
    logic                      accept;

    assign accept = out_valid && out_ready;

    // Position of the byte that follows the one currently presented.
    always_comb begin
        nxt_reg  = reg_idx;
        nxt_byte = byte_idx;
        nxt_hdr  = 1'b0;
        nxt_csum = 1'b0;
        case (state)
            HDR: nxt_byte = '0;
            DATA: begin
                if (byte_idx != BYTE_IDX_W'(3)) begin
                    nxt_byte = byte_idx + BYTE_IDX_W'(1);
                end else if (reg_idx == REG_IDX_W'(NUM_REGS - 1)) begin
                    nxt_csum = 1'b1;
                end else begin
                    nxt_reg  = reg_idx + REG_IDX_W'(1);
                    nxt_byte = '0;
                    nxt_hdr  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    reg_dump_mux #(
        .NUM_REGS(NUM_REGS),
        .HDR_TAG (HDR_TAG)
    ) u_mux (
        .snap    (snap),
        .reg_idx (nxt_reg),
        .byte_idx(nxt_byte),
        .hdr_sel (nxt_hdr),
        .byte_out(mux_byte)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            csum      <= '0;
            snap      <= '0;
            reg_idx   <= '0;
            byte_idx  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // The done cycle still counts as busy for start filtering.
                    if (start && !done) begin
                        snap      <= {rf7, rf6, rf5, rf4, rf3, rf2, rf1, rf0};
                        reg_idx   <= '0;
                        byte_idx  <= '0;
                        csum      <= '0;
                        state     <= HDR;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        out_data  <= {HDR_TAG, 1'b0, REG_IDX_W'(0)};
                    end
                end
                default: begin
                    if (accept) begin
                        csum <= csum ^ out_data;
                        if (state == CSUM) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            reg_idx  <= nxt_reg;
                            byte_idx <= nxt_byte;
                            if (nxt_csum) begin
                                state    <= CSUM;
                                out_data <= csum ^ out_data;
                            end else begin
                                state    <= nxt_hdr ? HDR : DATA;
                                out_data <= mux_byte;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_tx.sv
// Directed and randomized checks of reg_dump_tx against a frame-level reference model.
module tb_reg_dump_tx;
    import reg_dump_tx_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, out_ready;
    logic [31:0] rf [8];
    logic [7:0]  out_data;
    logic        out_valid, busy, done;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    reg_dump_tx dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rf0      (rf[0]),
        .rf1      (rf[1]),
        .rf2      (rf[2]),
        .rf3      (rf[3]),
        .rf4      (rf[4]),
        .rf5      (rf[5]),
        .rf6      (rf[6]),
        .rf7      (rf[7]),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .done     (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One frame: start pulse, then stream with the given ready probability.
    // Optional events are keyed to the number of bytes already accepted (-1 = never).
    task automatic dump(input int pct, input int start_at, input int chg_at,
                        input int rst_at, input bit start_on_done);
        logic [7:0] exp_q[$];
        logic [7:0] x, held;
        int nb, cyc, busy_cyc;
        bit hold_pending, aborted;
        exp_q = {};
        x = 8'h00;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'hA0 + 8'(i));
            for (int b = 3; b >= 0; b--) exp_q.push_back(rf[i][8*b +: 8]);
        end
        foreach (exp_q[k]) x ^= exp_q[k];
        exp_q.push_back(x);

        @(negedge clk);
        chk("idle_before_start", 32'({busy, out_valid, done}), 32'h0);
        start = 1'b1;
        out_ready = 1'($urandom_range(1));
        @(negedge clk);
        start = 1'b0;
        nb = 0; cyc = 1; busy_cyc = 0; hold_pending = 0; aborted = 0;
        while (nb < FRAME_BYTES && cyc < 1000) begin
            if (hold_pending) begin
                chk("hold_valid", 32'(out_valid), 32'h1);
                chk("hold_data", 32'(out_data), 32'(held));
            end
            chk("busy_valid_done", 32'({busy, out_valid, done}), 32'h6);
            if (busy) busy_cyc++;
            if (nb == chg_at) rf[3] = 32'hFFFF_FFFF;
            start = (nb == start_at);
            if (nb == rst_at) begin
                rst = 1'b1;
                out_ready = 1'($urandom_range(1));
                @(negedge clk);
                rst = 1'b0;
                start = 1'b0;
                chk("rst_abort", 32'({busy, out_valid, done, out_data}), 32'h0);
                for (int k = 0; k < 50; k++) begin
                    out_ready = 1'($urandom_range(1));
                    @(negedge clk);
                    chk("rst_quiet", 32'({busy, out_valid, done}), 32'h0);
                end
                aborted = 1;
                break;
            end
            out_ready = ($urandom_range(99) < pct);
            if (out_ready) begin
                chk($sformatf("byte%0d", nb), 32'(out_data), 32'(exp_q[nb]));
                nb++;
                hold_pending = 0;
            end else begin
                hold_pending = 1;
                held = out_data;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (!aborted) begin
            chk("frame_complete", 32'(nb), 32'(FRAME_BYTES));
            chk("done_cycle", 32'({busy, out_valid, done}), 32'h1);
            if (pct >= 100) begin
                chk("done_latency", 32'(cyc), 32'd42);
                chk("busy_cycles", 32'(busy_cyc), 32'd41);
            end
            if (start_on_done) start = 1'b1;
            out_ready = 1'($urandom_range(1));
            @(negedge clk);
            start = 1'b0;
            for (int k = 0; k < 3; k++) begin
                chk("idle_after_done", 32'({busy, out_valid, done}), 32'h0);
                out_ready = 1'($urandom_range(1));
                @(negedge clk);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) rf[i] = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset_state", 32'({busy, out_valid, done, out_data}), 32'h0);

        // start coincident with reset must be ignored
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        chk("start_with_rst", 32'({busy, out_valid, done}), 32'h0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("ready_while_idle", 32'({busy, out_valid, done}), 32'h0);

        // basic dump
        rf[3] = 32'h1234_5678;
        dump(100, -1, -1, -1, 1'b0);

        // all-zero registers
        for (int i = 0; i < 8; i++) rf[i] = 32'h0;
        dump(100, -1, -1, -1, 1'b0);

        // backpressure
        rf[3] = 32'h1234_5678;
        dump(50, -1, -1, -1, 1'b0);

        // snapshot isolation: rf3 changes mid-frame
        dump(50, -1, 12, -1, 1'b0);
        rf[3] = 32'h1234_5678;

        // start while busy and on the done cycle
        dump(100, 10, -1, -1, 1'b1);

        // reset mid-dump, then a fresh complete frame
        dump(70, -1, -1, 17, 1'b0);
        dump(100, -1, -1, -1, 1'b0);

        // randomized register contents and ready density
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 8; i++) rf[i] = $urandom();
            dump(int'($urandom_range(30, 100)), -1, -1, -1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
